// File: rtl/adg_711_sw_mon.sv
// Purpose:      receive-side monitor for the ADG711 switch-control square wave; measures each
//               half-period, checks it against HALF_NOM +/- TOL, and reports lock and fault status.
// Latency:      a sw_in change sampled at posedge k updates half_len/len_valid/locked/fault at posedge k+2.
// Backpressure: none; pure observer, len_valid is a one-cycle pulse with no ready.
//
// Ports:
//   CP         clock, all logic on posedge
//   CR         synchronous active-high reset
//   en         monitor enable; dropping it returns to IDLE (half_len retained)
//   sw_in      switch-control line, asynchronous to CP
//   level      synchronised sw_in (third flop of the sync chain)
//   half_len   last measured half-period in CP cycles
//   len_valid  one-cycle pulse when half_len updates
//   locked     high while LOCK_N consecutive in-tolerance half-periods have been seen
//   fault      high in FAULT (sticky until en=0 or CR)
//   fault_code 0 none, 1 timeout, 2 out-of-tolerance after lock
module adg_711_sw_mon #(
  parameter int CNT_W    = 21,
  parameter int HALF_NOM = 251,
  parameter int TOL      = 4,
  parameter int LOCK_N   = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             en,
  input  logic             sw_in,
  output logic             level,
  output logic [CNT_W-1:0] half_len,
  output logic             len_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int GW = $clog2(LOCK_N + 1);

  // Tolerance bounds held one bit wider than the counter so that
  // HALF_NOM - TOL never has to be formed (no underflow when TOL > HALF_NOM).
  localparam logic [CNT_W:0] NOM_X = (CNT_W+1)'(HALF_NOM);
  localparam logic [CNT_W:0] TOL_X = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    MEASURE   = 3'd2,
    LOCKED    = 3'd3,
    FAULT     = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [GW-1:0]    good_cnt, good_nx;
  logic [CNT_W-1:0] half_nx;
  logic             lv_nx;
  logic [1:0]       code_nx;

  logic             edge_det;
  logic             in_tol;
  logic             timeout;
  logic [CNT_W:0]   cnt_x;

  assign edge_det = s2 ^ s3;
  assign cnt_x    = {1'b0, cnt};
  assign in_tol   = ((cnt_x + TOL_X) >= NOM_X) && (cnt_x <= (NOM_X + TOL_X));
  assign timeout  = (cnt == TMO);

  assign level  = s3;
  assign locked = (state == LOCKED);
  assign fault  = (state == FAULT);

  always_ff @(posedge CP) begin
    if (CR) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      cnt        <= '0;
      good_cnt   <= '0;
      half_len   <= '0;
      len_valid  <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      state      <= state_nx;
      s1         <= sw_in;
      s2         <= s1;
      s3         <= s2;
      cnt        <= cnt_nx;
      good_cnt   <= good_nx;
      half_len   <= half_nx;
      len_valid  <= lv_nx;
      fault_code <= code_nx;
    end
  end

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    half_nx  = half_len;
    lv_nx    = 1'b0;
    code_nx  = fault_code;
    // Free-running half-period counter, restarted by every edge and
    // saturating so a dead line cannot wrap back into tolerance.
    if (edge_det)
      cnt_nx = CNT_W'(1);
    else if (&cnt)
      cnt_nx = cnt;
    else
      cnt_nx = cnt + CNT_W'(1);

    if (state != IDLE && !en) begin
      state_nx = IDLE;
      good_nx  = '0;
      code_nx  = 2'd0;
    end else begin
      case (state)
        IDLE: begin
          good_nx = '0;
          code_nx = 2'd0;
          if (en) begin
            state_nx = WAIT_EDGE;
            cnt_nx   = CNT_W'(1);
          end
        end
        WAIT_EDGE: begin
          // First edge only establishes phase; its count is meaningless.
          if (edge_det) begin
            state_nx = MEASURE;
            good_nx  = '0;
          end else if (timeout) begin
            state_nx = FAULT;
            code_nx  = 2'd1;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            half_nx = cnt;
            lv_nx   = 1'b1;
            if (in_tol) begin
              good_nx = good_cnt + GW'(1);
              if (good_cnt == GW'(LOCK_N - 1))
                state_nx = LOCKED;
            end else begin
              good_nx = '0;
            end
          end else if (timeout) begin
            state_nx = FAULT;
            code_nx  = 2'd1;
          end
        end
        LOCKED: begin
          if (edge_det) begin
            half_nx = cnt;
            lv_nx   = 1'b1;
            if (!in_tol) begin
              state_nx = FAULT;
              code_nx  = 2'd2;
            end
          end else if (timeout) begin
            state_nx = FAULT;
            code_nx  = 2'd1;
          end
        end
        FAULT: begin
          // Sticky: only en=0 or CR leaves.
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adg_711_sw_mon.sv
// Purpose:      directed self-checking bench for adg_711_sw_mon.
// Latency:      inputs driven 1 time unit after posedge, outputs sampled 1 time unit after posedge.
// Backpressure: not applicable.
module tb_adg_711_sw_mon;

  localparam int CNT_W   = 21;
  localparam int TIMEOUT = 1024;

  logic             CP;
  logic             CR;
  logic             en;
  logic             sw_in;
  logic             level;
  logic [CNT_W-1:0] half_len;
  logic             len_valid;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;

  int checks = 0;
  int errors = 0;

  adg_711_sw_mon #(
    .CNT_W    (CNT_W),
    .HALF_NOM (251),
    .TOL      (4),
    .LOCK_N   (4),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CP         (CP),
    .CR         (CR),
    .en         (en),
    .sw_in      (sw_in),
    .level      (level),
    .half_len   (half_len),
    .len_valid  (len_valid),
    .locked     (locked),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  initial begin
    #2000000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_lv, input int exp_len,
                         input logic exp_lk, input logic exp_ft, input int exp_code);
    chk({tag, "_len_valid"}, 32'(len_valid), 32'(exp_lv));
    chk({tag, "_half_len"},  32'(half_len),  32'(exp_len));
    chk({tag, "_locked"},    32'(locked),    32'(exp_lk));
    chk({tag, "_fault"},     32'(fault),     32'(exp_ft));
    chk({tag, "_code"},      32'(fault_code), 32'(exp_code));
  endtask

  // Toggle sw_in, check the outputs produced by that edge, and hold the
  // new level so that the next toggle comes n cycles after this one.
  task automatic edge_chk(input string tag, input int n, input logic exp_lv, input int exp_len,
                          input logic exp_lk, input logic exp_ft, input int exp_code);
    sw_in = ~sw_in;
    tick(2);
    chk({tag, "_pre_lv"}, 32'(len_valid), 32'd0);
    tick(1);
    chk({tag, "_level"}, 32'(level), 32'(sw_in));
    chk_all(tag, exp_lv, exp_len, exp_lk, exp_ft, exp_code);
    tick(1);
    chk({tag, "_post_lv"}, 32'(len_valid), 32'd0);
    tick(n - 4);
  endtask

  initial begin
    CR    = 1'b1;
    en    = 1'b0;
    sw_in = 1'b0;

    // 1: reset with sw_in toggling
    tick(1);
    chk("t1_rst0_level", 32'(level), 32'd0);
    chk_all("t1_rst0", 1'b0, 0, 1'b0, 1'b0, 0);
    sw_in = 1'b1;
    tick(1);
    chk("t1_rst1_level", 32'(level), 32'd0);
    chk_all("t1_rst1", 1'b0, 0, 1'b0, 1'b0, 0);
    CR = 1'b0;
    tick(2);
    chk("t1_level_lag", 32'(level), 32'd0);
    tick(1);
    chk("t1_level_follow", 32'(level), 32'd1);
    chk_all("t1_idle", 1'b0, 0, 1'b0, 1'b0, 0);

    // 2: acquisition at the nominal half period
    en = 1'b1;
    tick(1);
    edge_chk("t2e1", 251, 1'b0, 0,   1'b0, 1'b0, 0);
    edge_chk("t2e2", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t2e3", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t2e4", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t2e5", 255, 1'b1, 251, 1'b1, 1'b0, 0);

    // 3: tolerance boundaries while locked
    edge_chk("t3_255", 247, 1'b1, 255, 1'b1, 1'b0, 0);
    edge_chk("t3_247", 256, 1'b1, 247, 1'b1, 1'b0, 0);
    edge_chk("t3_256", 100, 1'b1, 256, 1'b0, 1'b1, 2);

    // 6: en dropped in the same cycle as an edge while in FAULT
    sw_in = ~sw_in;
    tick(2);
    en = 1'b0;
    tick(1);
    chk_all("t6_idle", 1'b0, 256, 1'b0, 1'b0, 0);
    tick(1);
    chk("t6_idle_lv", 32'(len_valid), 32'd0);
    en = 1'b1;
    tick(1);
    edge_chk("t6e1", 251, 1'b0, 256, 1'b0, 1'b0, 0);
    edge_chk("t6e2", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t6e3", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t6e4", 251, 1'b1, 251, 1'b0, 1'b0, 0);

    // 4: lock, then line goes quiet -> timeout exactly TIMEOUT cycles later
    sw_in = ~sw_in;
    tick(3);
    chk_all("t4_lock", 1'b1, 251, 1'b1, 1'b0, 0);
    tick(TIMEOUT - 1);
    chk_all("t4_before", 1'b0, 251, 1'b1, 1'b0, 0);
    tick(1);
    chk_all("t4_timeout", 1'b0, 251, 1'b0, 1'b1, 1);
    tick(5);
    chk_all("t4_sticky", 1'b0, 251, 1'b0, 1'b1, 1);

    // 5: an out-of-tolerance half period restarts the good count
    en = 1'b0;
    tick(1);
    chk_all("t5_clear", 1'b0, 251, 1'b0, 1'b0, 0);
    en = 1'b1;
    tick(1);
    edge_chk("t5e1", 251, 1'b0, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e2", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e3", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e4", 240, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e5", 251, 1'b1, 240, 1'b0, 1'b0, 0);
    edge_chk("t5e6", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e7", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e8", 251, 1'b1, 251, 1'b0, 1'b0, 0);
    edge_chk("t5e9", 10,  1'b1, 251, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
